ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single low-memory blockram (1 write port, 1 registered read port) between two requesters: port M (monitor load/dump/exec) and port C (cpu).
- Replaces the hard running-flag mux, so monitor and cpu may both issue accesses in the same period.
- Round-robin grant per cycle; optional lock for a requester that needs back-to-back ownership.
- Routes the 1-cycle-latency read data back to the issuing port with a valid strobe.

Parameters:
ADDR_WIDTH, 13, blockram address width (8K bytes)
DATA_WIDTH, 8, data width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m_req  in  1  monitor access request
m_we  in  1  1=write, 0=read; qualified by m_req
m_lock  in  1  monitor requests ownership past this access
m_addr  in  ADDR_WIDTH  monitor address
m_wdata  in  DATA_WIDTH  monitor write data
m_ready  out  1  monitor access accepted this cycle
m_rvalid  out  1  monitor read data valid
m_rdata  out  DATA_WIDTH  monitor read data
c_req, c_we, c_lock, c_addr, c_wdata, c_ready, c_rvalid, c_rdata  same as m_* for cpu
ram_waddr  out  ADDR_WIDTH  to ram waddr
ram_raddr  out  ADDR_WIDTH  to ram raddr
ram_din  out  DATA_WIDTH  to ram din
ram_write  out  1  to ram write_en
ram_dout  in  DATA_WIDTH  from ram dout

Behaviour:
- Reset, sampled on clk: state=ARB, last=C (so M wins the first conflict), rvalid pipe cleared, any lock dropped. While reset is high: m_ready=c_ready=0, ram_write=0, m_rvalid=c_rvalid=0.
- States: ARB, OWN_M, OWN_C.
- Grant g is combinational from state and requests:
  - ARB: a single requester is granted, even if it was last.
  - ARB, both requesting: the port != last is granted.
  - OWN_x: only x is granted; the other port's ready is held 0.
- x_ready = grant to x, same cycle as x_req. A requester holds req/addr/data until it sees ready.
- RAM drive is combinational from the granted port:
  - ram_raddr = ram_waddr = g.addr; ram_din = g.wdata; ram_write = g.req & g.we.
  - With no grant: ram_write=0 and addresses are held at the last value.
- Read latency: a read accepted in cycle N gives x_rvalid=1 for exactly cycle N+1, with x_rdata = ram_dout.
  - Tag register: 2 bits {M,C}, captured each cycle.
  - x_rdata is ram_dout when x_rvalid, otherwise the last value returned to x.
- Writes produce no rvalid.
- At most one access per cycle, so read/write collision is impossible. Back-to-back accepted reads on one port give continuous rvalid.
- last: updated to the granted port on every accepted access, in any state.
- Lock transitions:
  - ARB -> OWN_x when x is granted with x_lock=1.
  - OWN_x -> ARB when x_lock=0; the cycle that lock drops still grants x if x_req.
  - In OWN_x, x_req=0 with x_lock=1 stays in OWN_x; the resource idles and the other port is starved by design.
- Reset mid-read: the pending rvalid is suppressed; the state is ARB the next cycle.

Optional Feature:
- Macro: RAM_ARB_PERF_EN.
- When defined, three outputs are added:
  - m_grants [15:0]: accepted M accesses.
  - c_grants [15:0]: accepted C accesses.
  - conflicts [15:0]: cycles in ARB with both requests high, or in OWN_x with the other port requesting.
- All three saturate at 16'hffff, clear on reset, and update the cycle after the event.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - State encoding localparams ARB=2'd0, OWN_M=2'd1, OWN_C=2'd2.
  - Port index constants PORT_M=0, PORT_C=1.
  - Counter width 16.
- One sub-module: rr_grant2 (combinational 2-way round-robin picker: req[1:0], last -> grant[1:0]). The state, tag pipe and counters stay in ram_arbiter.

Test Plan:
- Reset then single M write m_addr=13'h0010, m_wdata=8'hA5 -> m_ready same cycle; ram_write=1, ram_waddr=0x0010, ram_din=0xA5; M read of 0x0010 -> m_rvalid next cycle, m_rdata=0xA5, c_rvalid=0.
- Both request reads every cycle (M 0x0000, C 0x0001) from reset -> grants M,C,M,C...; rvalids alternate one cycle behind; each port gets its own data.
- C asserts c_lock with reads for 4 cycles while M requests continuously -> m_ready=0 for those cycles; in the cycle c_lock drops, C is still granted; M is granted on the next cycle.
- Reset asserted in the cycle after an accepted C read -> c_rvalid=0, c_ready=0 and ram_write=0 during reset; after release, the first conflict grants M.
- Write by C to 0x1FFF, then M read of 0x1FFF the next cycle -> m_rdata shows the written byte; address top bit is preserved, no wrap.
- With RAM_ARB_PERF_EN: 10 both-request cycles in ARB -> conflicts=10, m_grants=5, c_grants=5; force 70000 conflicts -> conflicts stays at 16'hffff.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the low-memory blockram arbiter: FSM states, port indices,
// performance counter width and a saturating increment helper.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    OWN_M = 2'd1,
    OWN_C = 2'd2
  } arb_state_t;

  localparam bit PORT_M = 1'b0;
  localparam bit PORT_C = 1'b1;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_grant2.sv
// Combinational 2-way round-robin picker: a lone requester always wins,
// and on a conflict the port that was not granted last wins.
import ram_arbiter_pkg::*;

module rr_grant2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_req;
    if (&i_req)
      o_grant = (i_last == PORT_C) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port (monitor M, cpu C) arbiter in front of a 1W/1R registered-read blockram.
// Optional counters behind `RAM_ARB_PERF_EN: m_grants, c_grants, conflicts.
import ram_arbiter_pkg::*;

module ram_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m_req,
  input  logic                  m_we,
  input  logic                  m_lock,
  input  logic [ADDR_WIDTH-1:0] m_addr,
  input  logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_ready,
  output logic                  m_rvalid,
  output logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic                  c_lock,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_ready,
  output logic                  c_rvalid,
  output logic [DATA_WIDTH-1:0] c_rdata,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_write,
  input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]      m_grants,
  output logic [CNT_W-1:0]      c_grants,
  output logic [CNT_W-1:0]      conflicts
`endif
);

  arb_state_t            r_state;
  logic                  r_last;
  logic [1:0]            r_tag;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_m_rdata;
  logic [DATA_WIDTH-1:0] r_c_rdata;

  logic [1:0]            w_rr;
  logic [1:0]            w_grant;
  logic                  w_sel_c;
  logic                  w_any;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;

  rr_grant2 u_rr (
    .i_req   ({c_req, m_req}),
    .i_last  (r_last),
    .o_grant (w_rr)
  );

  // An owner excludes the other port entirely, even while the owner idles.
  always_comb begin
    w_grant = 2'b00;
    if (!reset) begin
      case (r_state)
        ARB:     w_grant = w_rr;
        OWN_M:   w_grant[PORT_M] = m_req;
        OWN_C:   w_grant[PORT_C] = c_req;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_sel_c = w_grant[PORT_C];
  assign w_any   = |w_grant;
  assign w_addr  = w_sel_c ? c_addr : m_addr;
  assign w_we    = w_sel_c ? c_we   : m_we;

  assign m_ready   = w_grant[PORT_M];
  assign c_ready   = w_grant[PORT_C];
  assign ram_waddr = w_any ? w_addr : r_addr;
  assign ram_raddr = w_any ? w_addr : r_addr;
  assign ram_din   = w_sel_c ? c_wdata : m_wdata;
  assign ram_write = w_any & w_we;

  // Reset masks a read issued the cycle before it was asserted.
  assign m_rvalid = r_tag[PORT_M] & ~reset;
  assign c_rvalid = r_tag[PORT_C] & ~reset;
  assign m_rdata  = m_rvalid ? ram_dout : r_m_rdata;
  assign c_rdata  = c_rvalid ? ram_dout : r_c_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ARB;
      r_last    <= PORT_C;
      r_tag     <= 2'b00;
      r_addr    <= '0;
      r_m_rdata <= '0;
      r_c_rdata <= '0;
    end else begin
      r_tag[PORT_M] <= w_grant[PORT_M] & ~m_we;
      r_tag[PORT_C] <= w_grant[PORT_C] & ~c_we;
      if (r_tag[PORT_M]) r_m_rdata <= ram_dout;
      if (r_tag[PORT_C]) r_c_rdata <= ram_dout;
      if (w_any) begin
        r_last <= w_sel_c;
        r_addr <= w_addr;
      end
      case (r_state)
        ARB: begin
          if (w_grant[PORT_M] && m_lock)      r_state <= OWN_M;
          else if (w_grant[PORT_C] && c_lock) r_state <= OWN_C;
        end
        OWN_M:   if (!m_lock) r_state <= ARB;
        OWN_C:   if (!c_lock) r_state <= ARB;
        default: r_state <= ARB;
      endcase
    end
  end

`ifdef RAM_ARB_PERF_EN
  logic [CNT_W-1:0] r_m_grants;
  logic [CNT_W-1:0] r_c_grants;
  logic [CNT_W-1:0] r_conflicts;
  logic             w_conflict;

  always_comb begin
    w_conflict = 1'b0;
    case (r_state)
      ARB:     w_conflict = m_req & c_req;
      OWN_M:   w_conflict = c_req;
      OWN_C:   w_conflict = m_req;
      default: w_conflict = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_grants  <= '0;
      r_c_grants  <= '0;
      r_conflicts <= '0;
    end else begin
      r_m_grants  <= sat_inc(r_m_grants, w_grant[PORT_M]);
      r_c_grants  <= sat_inc(r_c_grants, w_grant[PORT_C]);
      r_conflicts <= sat_inc(r_conflicts, w_conflict);
    end
  end

  assign m_grants  = r_m_grants;
  assign c_grants  = r_c_grants;
  assign conflicts = r_conflicts;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural blockram model.
module tb_ram_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          m_req, m_we, m_lock;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ready, m_rvalid;
  logic [DW-1:0] m_rdata;
  logic          c_req, c_we, c_lock;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_ready, c_rvalid;
  logic [DW-1:0] c_rdata;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_write;
`ifdef RAM_ARB_PERF_EN
  logic [15:0]   m_grants, c_grants, conflicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write) mem[ram_waddr] <= ram_din;
    ram_dout <= mem[ram_raddr];
  end

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_lock(m_lock), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ready(c_ready), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_din(ram_din),
    .ram_write(ram_write), .ram_dout(ram_dout)
`ifdef RAM_ARB_PERF_EN
    , .m_grants(m_grants), .c_grants(c_grants), .conflicts(conflicts)
`endif
  );

  task automatic idle();
    m_req = 0; m_we = 0; m_lock = 0; m_addr = '0; m_wdata = '0;
    c_req = 0; c_we = 0; c_lock = 0; c_addr = '0; c_wdata = '0;
  endtask

  // Leaves the bench just after a negedge with reset low.
  task automatic do_reset();
    reset = 1; idle();
    @(negedge clk); @(negedge clk);
    reset = 0;
  endtask

  task automatic m_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_req = 1; m_we = 1; m_addr = a; m_wdata = d;
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    reset = 1; idle();
    m_req = 1; m_we = 1; c_req = 1; c_we = 1;
    @(negedge clk); #1;
    n_checks++; if (m_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_m_ready got=%b exp=0", m_ready); end
    n_checks++; if (c_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_c_ready got=%b exp=0", c_ready); end
    n_checks++; if (ram_write !== 1'b0) begin n_fail++; $display("FAIL rst_ram_write got=%b exp=0", ram_write); end
    n_checks++; if (m_rvalid !== 1'b0)  begin n_fail++; $display("FAIL rst_m_rvalid got=%b exp=0", m_rvalid); end
    n_checks++; if (c_rvalid !== 1'b0)  begin n_fail++; $display("FAIL rst_c_rvalid got=%b exp=0", c_rvalid); end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_single_m();
    do_reset();
    m_req = 1; m_we = 1; m_addr = 13'h0010; m_wdata = 8'hA5; #1;
    n_checks++; if (m_ready !== 1'b1)        begin n_fail++; $display("FAIL wr_m_ready got=%b exp=1", m_ready); end
    n_checks++; if (ram_write !== 1'b1)      begin n_fail++; $display("FAIL wr_ram_write got=%b exp=1", ram_write); end
    n_checks++; if (ram_waddr !== 13'h0010)  begin n_fail++; $display("FAIL wr_waddr got=%h exp=0010", ram_waddr); end
    n_checks++; if (ram_din !== 8'hA5)       begin n_fail++; $display("FAIL wr_din got=%h exp=a5", ram_din); end
    @(negedge clk);
    m_we = 0; #1;
    n_checks++; if (m_ready !== 1'b1)        begin n_fail++; $display("FAIL rd_m_ready got=%b exp=1", m_ready); end
    n_checks++; if (ram_write !== 1'b0)      begin n_fail++; $display("FAIL rd_ram_write got=%b exp=0", ram_write); end
    n_checks++; if (ram_raddr !== 13'h0010)  begin n_fail++; $display("FAIL rd_raddr got=%h exp=0010", ram_raddr); end
    @(negedge clk);
    idle(); #1;
    n_checks++; if (m_rvalid !== 1'b1)       begin n_fail++; $display("FAIL rd_m_rvalid got=%b exp=1", m_rvalid); end
    n_checks++; if (m_rdata !== 8'hA5)       begin n_fail++; $display("FAIL rd_m_rdata got=%h exp=a5", m_rdata); end
    n_checks++; if (c_rvalid !== 1'b0)       begin n_fail++; $display("FAIL rd_c_rvalid got=%b exp=0", c_rvalid); end
    n_checks++; if (ram_raddr !== 13'h0010)  begin n_fail++; $display("FAIL idle_addr_hold got=%h exp=0010", ram_raddr); end
    @(negedge clk); #1;
    n_checks++; if (m_rvalid !== 1'b0)       begin n_fail++; $display("FAIL hold_m_rvalid got=%b exp=0", m_rvalid); end
    n_checks++; if (m_rdata !== 8'hA5)       begin n_fail++; $display("FAIL hold_m_rdata got=%h exp=a5", m_rdata); end
  endtask

  task automatic test_round_robin();
    do_reset();
    m_write(13'h0000, 8'h11);
    m_write(13'h0001, 8'h22);
    do_reset();
    m_req = 1; m_we = 0; m_addr = 13'h0000;
    c_req = 1; c_we = 0; c_addr = 13'h0001;
    for (int k = 0; k < 6; k++) begin
      logic em, ec, evm, evc;
      em  = (k % 2 == 0);
      ec  = !em;
      evm = (k > 0) && ((k - 1) % 2 == 0);
      evc = (k > 0) && !evm;
      #1;
      n_checks++; if (m_ready !== em)  begin n_fail++; $display("FAIL rr_m_ready[%0d] got=%b exp=%b", k, m_ready, em); end
      n_checks++; if (c_ready !== ec)  begin n_fail++; $display("FAIL rr_c_ready[%0d] got=%b exp=%b", k, c_ready, ec); end
      n_checks++; if (m_rvalid !== evm) begin n_fail++; $display("FAIL rr_m_rvalid[%0d] got=%b exp=%b", k, m_rvalid, evm); end
      n_checks++; if (c_rvalid !== evc) begin n_fail++; $display("FAIL rr_c_rvalid[%0d] got=%b exp=%b", k, c_rvalid, evc); end
      if (evm) begin
        n_checks++; if (m_rdata !== 8'h11) begin n_fail++; $display("FAIL rr_m_rdata[%0d] got=%h exp=11", k, m_rdata); end
      end
      if (evc) begin
        n_checks++; if (c_rdata !== 8'h22) begin n_fail++; $display("FAIL rr_c_rdata[%0d] got=%h exp=22", k, c_rdata); end
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_lock();
    do_reset();
    c_req = 1; c_we = 0; c_lock = 1; c_addr = 13'h0001; #1;
    n_checks++; if (c_ready !== 1'b1) begin n_fail++; $display("FAIL lk0_c_ready got=%b exp=1", c_ready); end
    @(negedge clk);
    m_req = 1; m_we = 0; m_addr = 13'h0000;
    for (int k = 1; k < 4; k++) begin
      #1;
      n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL lk%0d_m_ready got=%b exp=0", k, m_ready); end
      n_checks++; if (c_ready !== 1'b1) begin n_fail++; $display("FAIL lk%0d_c_ready got=%b exp=1", k, c_ready); end
      @(negedge clk);
    end
    c_lock = 0; #1;
    n_checks++; if (c_ready !== 1'b1) begin n_fail++; $display("FAIL unlk_c_ready got=%b exp=1", c_ready); end
    n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL unlk_m_ready got=%b exp=0", m_ready); end
    @(negedge clk); #1;
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL post_m_ready got=%b exp=1", m_ready); end
    n_checks++; if (c_ready !== 1'b0) begin n_fail++; $display("FAIL post_c_ready got=%b exp=0", c_ready); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    c_req = 1; c_we = 0; c_lock = 1; c_addr = 13'h0001; #1;
    n_checks++; if (c_ready !== 1'b1) begin n_fail++; $display("FAIL mr_c_ready got=%b exp=1", c_ready); end
    @(negedge clk);
    reset = 1; m_req = 1; m_we = 1; #1;
    n_checks++; if (c_rvalid !== 1'b0)  begin n_fail++; $display("FAIL mr_c_rvalid got=%b exp=0", c_rvalid); end
    n_checks++; if (c_ready !== 1'b0)   begin n_fail++; $display("FAIL mr_rst_c_ready got=%b exp=0", c_ready); end
    n_checks++; if (m_ready !== 1'b0)   begin n_fail++; $display("FAIL mr_rst_m_ready got=%b exp=0", m_ready); end
    n_checks++; if (ram_write !== 1'b0) begin n_fail++; $display("FAIL mr_ram_write got=%b exp=0", ram_write); end
    @(negedge clk);
    reset = 0; m_we = 0; #1;
    n_checks++; if (m_ready !== 1'b1)  begin n_fail++; $display("FAIL mr_post_m_ready got=%b exp=1", m_ready); end
    n_checks++; if (c_ready !== 1'b0)  begin n_fail++; $display("FAIL mr_post_c_ready got=%b exp=0", c_ready); end
    n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL mr_post_c_rvalid got=%b exp=0", c_rvalid); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_top_addr();
    do_reset();
    c_req = 1; c_we = 1; c_addr = 13'h1FFF; c_wdata = 8'h5C; #1;
    n_checks++; if (ram_write !== 1'b1)     begin n_fail++; $display("FAIL top_ram_write got=%b exp=1", ram_write); end
    n_checks++; if (ram_waddr !== 13'h1FFF) begin n_fail++; $display("FAIL top_waddr got=%h exp=1fff", ram_waddr); end
    @(negedge clk);
    idle(); m_req = 1; m_addr = 13'h1FFF; #1;
    n_checks++; if (ram_raddr !== 13'h1FFF) begin n_fail++; $display("FAIL top_raddr got=%h exp=1fff", ram_raddr); end
    @(negedge clk);
    idle(); #1;
    n_checks++; if (m_rvalid !== 1'b1) begin n_fail++; $display("FAIL top_m_rvalid got=%b exp=1", m_rvalid); end
    n_checks++; if (m_rdata !== 8'h5C) begin n_fail++; $display("FAIL top_m_rdata got=%h exp=5c", m_rdata); end
    n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL top_c_rvalid got=%b exp=0", c_rvalid); end
    @(negedge clk);
  endtask

`ifdef RAM_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    m_req = 1; c_req = 1; m_addr = 13'h0000; c_addr = 13'h0001;
    repeat (10) @(negedge clk);
    idle(); #1;
    n_checks++; if (conflicts !== 16'd10) begin n_fail++; $display("FAIL pf_conflicts got=%0d exp=10", conflicts); end
    n_checks++; if (m_grants !== 16'd5)   begin n_fail++; $display("FAIL pf_m_grants got=%0d exp=5", m_grants); end
    n_checks++; if (c_grants !== 16'd5)   begin n_fail++; $display("FAIL pf_c_grants got=%0d exp=5", c_grants); end
    m_req = 1; c_req = 1;
    repeat (70000) @(negedge clk);
    idle(); #1;
    n_checks++; if (conflicts !== 16'hFFFF) begin n_fail++; $display("FAIL pf_sat got=%h exp=ffff", conflicts); end
    n_checks++; if (m_grants !== 16'd35005) begin n_fail++; $display("FAIL pf_m_grants2 got=%0d exp=35005", m_grants); end
    @(negedge clk); #1;
    n_checks++; if (conflicts !== 16'hFFFF) begin n_fail++; $display("FAIL pf_sat_hold got=%h exp=ffff", conflicts); end
  endtask
`endif

  initial begin
    reset = 1; idle();
    test_reset();
    test_single_m();
    test_round_robin();
    test_lock();
    test_reset_mid_read();
    test_top_addr();
`ifdef RAM_ARB_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
